// File: rtl/gals_rr_arbiter.sv
// Two-producer round-robin arbiter forwarding 4-phase bundled-data words to a single consumer.
// Optional c_ack watchdog: define GALS_ARB_TIMEOUT_EN to build the timeout counter and sticky err flag.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no owner; waiting for a synchronized producer request
// WAIT_ACK  | c_req high with latched word; waiting for consumer ack
// WAIT_NACK | c_req low; waiting for consumer ack to return low
// RELEASE   | ack to owner high; waiting for owner to drop its request
module gals_rr_arbiter #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 200000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ack,
  output logic              c_req,
  output logic [DATA_W-1:0] c_data,
  input  logic              c_ack,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err
);

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_check
    $error("gals_rr_arbiter: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] p0_sync;
  logic [SYNC_STAGES-1:0] p1_sync;
  logic [SYNC_STAGES-1:0] c_ack_sync;
  logic                   p0_req_s;
  logic                   p1_req_s;
  logic                   c_ack_s;

  logic sel;   // owner of the current transaction: 0 = p0, 1 = p1
  logic last;  // owner of the most recently completed transaction
  logic pick;
  logic sel_req_s;
  logic timeout_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p0_sync    <= '0;
      p1_sync    <= '0;
      c_ack_sync <= '0;
    end else begin
      p0_sync    <= {p0_sync[SYNC_STAGES-2:0], p0_req};
      p1_sync    <= {p1_sync[SYNC_STAGES-2:0], p1_req};
      c_ack_sync <= {c_ack_sync[SYNC_STAGES-2:0], c_ack};
    end
  end

  assign p0_req_s  = p0_sync[SYNC_STAGES-1];
  assign p1_req_s  = p1_sync[SYNC_STAGES-1];
  assign c_ack_s   = c_ack_sync[SYNC_STAGES-1];
  assign sel_req_s = sel ? p1_req_s : p0_req_s;

  // On a tie the producer that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (p0_req_s && p1_req_s) begin
      pick = ~last;
    end else if (p1_req_s) begin
      pick = 1'b1;
    end
  end

`ifdef GALS_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;

  assign timeout_hit = (state == WAIT_ACK) && !c_ack_s && (wait_cnt == 32'(TIMEOUT - 1));

  // Counter sits at zero outside WAIT_ACK, so it is clear on every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == WAIT_ACK) begin
        wait_cnt <= wait_cnt + 32'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= 1'b0;
      last   <= 1'b1;
      c_req  <= 1'b0;
      c_data <= '0;
      grant  <= 2'b00;
      busy   <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req_s || p1_req_s) begin
            sel    <= pick;
            c_data <= pick ? p1_data : p0_data;
            c_req  <= 1'b1;
            grant  <= pick ? 2'b10 : 2'b01;
            busy   <= 1'b1;
            state  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A timeout drops the word but still walks the owner through a normal release.
          if (c_ack_s || timeout_hit) begin
            c_req <= 1'b0;
            state <= WAIT_NACK;
          end
        end
        WAIT_NACK: begin
          if (!c_ack_s) begin
            if (sel) begin
              p1_ack <= 1'b1;
            end else begin
              p0_ack <= 1'b1;
            end
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!sel_req_s) begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            grant  <= 2'b00;
            busy   <= 1'b0;
            last   <= sel;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gals_rr_arbiter.sv
// Scoreboard bench for gals_rr_arbiter: producer/consumer 4-phase agents, invariant monitor.
// Timeout behaviour is checked according to GALS_ARB_TIMEOUT_EN as seen by this compile.
module tb_gals_rr_arbiter;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0;
  logic          p1_req = 1'b0;
  logic          c_ack = 1'b0;
  logic [DW-1:0] p0_data = '0;
  logic [DW-1:0] p1_data = '0;
  logic [DW-1:0] c_data;
  logic          p0_ack;
  logic          p1_ack;
  logic          c_req;
  logic [1:0]    grant;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  bit cons_en = 1'b1;
  int cons_delay = 5;

  typedef struct packed {
    logic [1:0]    g;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];

  gals_rr_arbiter #(
    .DATA_W(DW),
    .SYNC_STAGES(2),
    .TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .p0_req(p0_req),
    .p0_data(p0_data),
    .p0_ack(p0_ack),
    .p1_req(p1_req),
    .p1_data(p1_data),
    .p1_ack(p1_ack),
    .c_req(c_req),
    .c_data(c_data),
    .c_ack(c_ack),
    .grant(grant),
    .busy(busy),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_tx(input logic [1:0] g, input logic [DW-1:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sb.push_back(e);
  endtask

  // One full 4-phase producer transaction; bounded waits on the ack.
  task automatic produce(input int p, input logic [DW-1:0] d);
    int n;
    if (p == 0) begin
      p0_data = d;
      p0_req  = 1'b1;
    end else begin
      p1_data = d;
      p1_req  = 1'b1;
    end
    n = 0;
    while (((p == 0) ? p0_ack : p1_ack) == 1'b0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check_val((p == 0) ? "p0_ack_rise" : "p1_ack_rise", (p == 0) ? p0_ack : p1_ack, 1);
    if (p == 0) p0_req = 1'b0;
    else p1_req = 1'b0;
    n = 0;
    while (((p == 0) ? p0_ack : p1_ack) == 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check_val((p == 0) ? "p0_ack_fall" : "p1_ack_fall", (p == 0) ? p0_ack : p1_ack, 0);
  endtask

  // Consumer agent: scoreboard pop on each c_req rise, ack after cons_delay cycles.
  bit   cons_seen = 1'b0;
  int   cons_cnt = 0;
  exp_t cons_e;
  initial begin
    forever begin
      @(negedge clock);
      if (reset || !c_req) begin
        c_ack     = 1'b0;
        cons_seen = 1'b0;
      end else if (!cons_seen) begin
        cons_seen = 1'b1;
        cons_cnt  = 0;
        check_val("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          cons_e = sb.pop_front();
          check_val("c_data", c_data, cons_e.d);
          check_val("grant", grant, cons_e.g);
        end
      end else if (!c_ack && cons_en) begin
        cons_cnt++;
        if (cons_cnt >= cons_delay) c_ack = 1'b1;
      end
    end
  end

  // Invariant monitor.
  logic [DW-1:0] prev_data = '0;
  bit            prev_creq = 1'b0;
  bit            prev_rst = 1'b1;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && !prev_rst) begin
        check_val("ack_exclusive", p0_ack & p1_ack, 0);
        check_val("creq_ack_exclusive", c_req & (p0_ack | p1_ack), 0);
        check_val("grant_onehot0", ($countones(grant) <= 1), 1);
        check_val("p1_ack_while_g0", grant[0] & p1_ack, 0);
        check_val("p0_ack_while_g1", grant[1] & p0_ack, 0);
        check_val("busy_vs_grant", busy, (grant != 2'b00));
        if (!(c_req && !prev_creq)) check_val("c_data_hold", c_data, prev_data);
      end
      prev_data = c_data;
      prev_creq = c_req;
      prev_rst  = reset;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_val("rst_c_req", c_req, 0);
    check_val("rst_grant", grant, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err", err, 0);
    check_val("rst_c_data", c_data, 0);
    check_val("rst_acks", {p0_ack, p1_ack}, 0);
    reset = 1'b0;
    @(negedge clock);

    // single transfer, latency SYNC_STAGES + 1
    cons_en = 1'b1;
    cons_delay = 5;
    expect_tx(2'b01, 8'hA5);
    fork
      produce(0, 8'hA5);
      begin
        repeat (2) @(negedge clock);
        check_val("lat_edge2_c_req", c_req, 0);
        @(negedge clock);
        check_val("lat_edge3_c_req", c_req, 1);
        check_val("lat_edge3_c_data", c_data, 8'hA5);
        check_val("lat_edge3_grant", grant, 2'b01);
      end
    join
    check_val("single_end_grant", grant, 0);
    check_val("single_end_busy", busy, 0);
    check_val("single_end_c_data", c_data, 8'hA5);

    // tie from reset: p0 first
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    expect_tx(2'b01, 8'h11);
    expect_tx(2'b10, 8'h22);
    fork
      produce(0, 8'h11);
      produce(1, 8'h22);
    join
    check_val("tie_end_grant", grant, 0);

    // fairness: alternating grants under contention
    cons_delay = 2;
    expect_tx(2'b01, 8'hA1);
    expect_tx(2'b10, 8'hB1);
    expect_tx(2'b01, 8'hA2);
    expect_tx(2'b10, 8'hB2);
    fork
      begin
        produce(0, 8'hA1);
        produce(0, 8'hA2);
      end
      begin
        produce(1, 8'hB1);
        produce(1, 8'hB2);
      end
    join

    // reset mid-operation
    @(negedge clock);
    cons_en = 1'b0;
    expect_tx(2'b01, 8'h33);
    p0_data = 8'h33;
    p0_req  = 1'b1;
    n = 0;
    while (!c_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("mid_c_req_up", c_req, 1);
    p1_data = 8'h44;
    p1_req  = 1'b1;
    repeat (4) @(negedge clock);
    check_val("mid_wait_ack", c_req & busy, 1);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_c_req", c_req, 0);
    check_val("async_rst_grant", grant, 0);
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_acks", {p0_ack, p1_ack}, 0);
    check_val("async_rst_c_data", c_data, 0);
    @(negedge clock);
    reset = 1'b0;
    cons_en = 1'b1;
    expect_tx(2'b01, 8'h33);
    expect_tx(2'b10, 8'h44);
    fork
      produce(0, 8'h33);
      produce(1, 8'h44);
    join

    // consumer never acks; p1 pulses a request while the arbiter is busy
    @(negedge clock);
    cons_en = 1'b0;
    expect_tx(2'b01, 8'h5A);
    fork
      produce(0, 8'h5A);
      begin
        n = 0;
        while (!c_req && n < 50) begin
          @(negedge clock);
          n++;
        end
        check_val("to_c_req_up", c_req, 1);
        n = 0;
`ifdef GALS_ARB_TIMEOUT_EN
        while (c_req && n < 100) begin
          @(negedge clock);
          n++;
          if (n == 1) begin
            p1_data = 8'h77;
            p1_req  = 1'b1;
          end
          if (n == 4) p1_req = 1'b0;
        end
        check_val("to_c_req_fall_cycles", n, 16);
        check_val("to_err_set", err, 1);
`else
        while (n < 100) begin
          @(negedge clock);
          n++;
          if (n == 1) begin
            p1_data = 8'h77;
            p1_req  = 1'b1;
          end
          if (n == 4) p1_req = 1'b0;
        end
        check_val("noto_c_req_held", c_req, 1);
        check_val("noto_err", err, 0);
        cons_en = 1'b1;
`endif
      end
    join
    repeat (10) @(negedge clock);
    check_val("dropped_req_no_c_req", c_req, 0);
    check_val("dropped_req_no_grant", grant, 0);
`ifdef GALS_ARB_TIMEOUT_EN
    check_val("err_sticky", err, 1);
    reset = 1'b1;
    @(negedge clock);
    check_val("err_cleared_by_reset", err, 0);
    reset = 1'b0;
    @(negedge clock);
`else
    check_val("noto_err_end", err, 0);
`endif

    check_val("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
